fpq_scan_nch: RTL and testbench

- Parametrised multi-channel event scanner; successor to the fixed 1-tester/2-channel FPQ top.
- Synchronises and debounces NCH asynchronous inputs and classifies each settled transition as H (rose to 1) or L (fell to 0).
- Queues events per channel and presents them one at a time on the `active`/`channel` display bus using round-robin arbitration.
- Sits directly under the FPQ top and drives the same `active`/`channel` encoding.

---
 rtl/fpq_scan_nch_if.sv | 28 ++
 rtl/fpq_scan_nch.sv | 198 +++++++++++++++++++
 tb/tb_fpq_scan_nch.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fpq_scan_nch_if.sv
// Display bus for the FPQ channel scanner.
// Raw channel levels and clear go in; active/channel/pend_any come out.
interface fpq_scan_nch_if #(
  parameter int NCH = 16,
  parameter int CW  = 4
);
  logic [NCH-1:0] ch_in;
  logic           clr;
  logic [1:0]     active;
  logic [CW-1:0]  channel;
  logic           pend_any;

  modport master (
    input  ch_in,
    input  clr,
    output active,
    output channel,
    output pend_any
  );

  modport slave (
    output ch_in,
    output clr,
    input  active,
    input  channel,
    input  pend_any
  );
endinterface

// File: rtl/fpq_scan_nch.sv
// Multi-channel debounced event scanner with round-robin display.
// Define FPQ_LOCK_EN for quiz lockout (first event latched until clr).
module fpq_scan_nch #(
  parameter int NCH         = 16,
  parameter int CW          = 4,
  parameter int DEB_CYCLES  = 12000,
  parameter int HOLD_CYCLES = 1200000
) (
  input  logic          clk_12MHz,
  input  logic          rst_n,
  fpq_scan_nch_if.master bus
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  logic [NCH-1:0] s1, s2, deb;
  logic [DW-1:0]  cnt [NCH];
  logic [NCH-1:0] flip, rise, fall;

  logic [NCH-1:0] pend_h, pend_l, pend;
  logic [NCH-1:0] clr_h, clr_l, set_en;
  logic [CW-1:0]  ptr, ptr_n;
  logic [CW-1:0]  gidx;
  logic           found;

  state_t         state, state_n;
  logic [HW-1:0]  hold, hold_n;
  logic [1:0]     act, act_n;
  logic [CW-1:0]  chn, chn_n;
  logic           pany;

  // Input path: synchroniser + per-channel debounce
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      flip[i] = (s2[i] != deb[i]) &&
                (cnt[i] == DW'(DEB_CYCLES - 1));
    end
    rise = flip & ~deb;
    fall = flip & deb;
  end

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= '0;
      s2  <= '0;
      deb <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      s1 <= bus.ch_in;
      s2 <= s1;
      for (int i = 0; i < NCH; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (flip[i]) begin
          cnt[i] <= '0;
          deb[i] <= ~deb[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Round-robin pick: lowest offset from ptr wins
  assign pend = pend_h | pend_l;

  always_comb begin
    int j;
    found = 1'b0;
    gidx  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NCH) j = j - NCH;
      if (pend[j]) begin
        found = 1'b1;
        gidx  = CW'(j);
      end
    end
  end

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (found) state_n = SHOW;
`ifdef FPQ_LOCK_EN
      SHOW: state_n = SHOW;
`else
      SHOW: if (hold == HW'(HOLD_CYCLES - 1))
              state_n = GAP;
`endif
      GAP:  state_n = found ? SHOW : IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.clr) state_n = IDLE;
  end

  always_comb begin
    act_n  = act;
    chn_n  = chn;
    hold_n = hold;
    ptr_n  = ptr;
    clr_h  = '0;
    clr_l  = '0;
    unique case (state)
      IDLE, GAP: begin
        act_n = 2'b00;
        chn_n = '0;
        if (found) begin
          act_n  = pend_h[gidx] ? 2'b01 : 2'b10;
          chn_n  = gidx;
          hold_n = '0;
          ptr_n  = (int'(gidx) == NCH - 1) ?
                   '0 : gidx + 1'b1;
`ifdef FPQ_LOCK_EN
          clr_h = '1;
          clr_l = '1;
`else
          clr_h[gidx] = pend_h[gidx];
          clr_l[gidx] = ~pend_h[gidx];
`endif
        end
      end
      SHOW: begin
`ifndef FPQ_LOCK_EN
        if (hold == HW'(HOLD_CYCLES - 1)) begin
          act_n = 2'b00;
          chn_n = '0;
        end else begin
          hold_n = hold + 1'b1;
        end
`endif
      end
      default: begin
        act_n = 2'b00;
        chn_n = '0;
      end
    endcase
    if (bus.clr) begin
      act_n = 2'b00;
      chn_n = '0;
    end
  end

`ifdef FPQ_LOCK_EN
  // Once anything is granted, new flips are dropped until clr
  assign set_en = (state == IDLE && !found) ?
                  '1 : '0;
`else
  assign set_en = '1;
`endif

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      act    <= 2'b00;
      chn    <= '0;
      hold   <= '0;
      ptr    <= '0;
      pend_h <= '0;
      pend_l <= '0;
      pany   <= 1'b0;
    end else begin
      act  <= act_n;
      chn  <= chn_n;
      hold <= hold_n;
      ptr  <= ptr_n;
      if (bus.clr) begin
        pend_h <= '0;
        pend_l <= '0;
        pany   <= 1'b0;
      end else begin
        pend_h <= (pend_h & ~clr_h) | (rise & set_en);
        pend_l <= (pend_l & ~clr_l) | (fall & set_en);
`ifdef FPQ_LOCK_EN
        pany <= 1'b0;
`else
        pany <= |pend;
`endif
      end
    end
  end

  assign bus.active   = act;
  assign bus.channel  = chn;
  assign bus.pend_any = pany;

endmodule

// File: tb/tb_fpq_scan_nch.sv
// Directed bench for fpq_scan_nch (NCH=4, DEB=4, HOLD=8).
// Segment tables give per-cycle expected display outputs.
module tb_fpq_scan_nch;

  localparam int NCH  = 4;
  localparam int CW   = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fpq_scan_nch_if #(.NCH(NCH), .CW(CW)) bus();

  fpq_scan_nch #(
    .NCH(NCH),
    .CW(CW),
    .DEB_CYCLES(DEB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_12MHz(clk),
    .rst_n(rst_n),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ch;
    logic       clr;
    int         n;
    logic [1:0] act;
    logic [1:0] chn;
    logic       pa;
  } seg_t;

  seg_t tbl[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name,
                       input logic [1:0] a,
                       input logic [1:0] c,
                       input logic p);
    tests++;
    if (bus.active !== a || bus.channel !== c ||
        bus.pend_any !== p) begin
      fails++;
      $display("FAIL %s: got act=%b ch=%0d pa=%b, want act=%b ch=%0d pa=%b",
               name, bus.active, bus.channel, bus.pend_any,
               a, c, p);
    end
  endtask

  function automatic void add(input logic [3:0] ch,
                              input logic clr, input int n,
                              input logic [1:0] act,
                              input logic [1:0] chn,
                              input logic pa);
    seg_t s;
    s.ch = ch; s.clr = clr; s.n = n;
    s.act = act; s.chn = chn; s.pa = pa;
    tbl.push_back(s);
  endfunction

  task automatic run_tbl(input string tag);
    foreach (tbl[k]) begin
      @(negedge clk);
      bus.ch_in = tbl[k].ch;
      bus.clr   = tbl[k].clr;
      for (int c = 0; c < tbl[k].n; c++) begin
        @(posedge clk);
        #1;
        check($sformatf("%s.s%0d.c%0d", tag, k, c),
              tbl[k].act, tbl[k].chn, tbl[k].pa);
      end
    end
    tbl.delete();
  endtask

  initial begin
    bus.ch_in = '0;
    bus.clr   = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_hold", 2'b00, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_state", 2'b00, 2'd0, 1'b0);

`ifndef FPQ_LOCK_EN
    // single event on ch2: rise then fall
    add(4'b0100, 0, 6, 2'b00, 2'd0, 0);
    add(4'b0100, 0, 1, 2'b01, 2'd2, 1);
    add(4'b0100, 0, 7, 2'b01, 2'd2, 0);
    add(4'b0100, 0, 2, 2'b00, 2'd0, 0);
    add(4'b0000, 0, 6, 2'b00, 2'd0, 0);
    add(4'b0000, 0, 1, 2'b10, 2'd2, 1);
    add(4'b0000, 0, 7, 2'b10, 2'd2, 0);
    add(4'b0000, 0, 2, 2'b00, 2'd0, 0);
    // 3-cycle glitch on ch1
    add(4'b0010, 0, 3, 2'b00, 2'd0, 0);
    add(4'b0000, 0, 8, 2'b00, 2'd0, 0);
    run_tbl("single");

    // async reset in the middle of a display
    @(negedge clk);
    bus.ch_in = 4'b0100;
    repeat (9) @(posedge clk);
    #1 check("rst_pre", 2'b01, 2'd2, 1'b0);
    #2;
    bus.ch_in = 4'b0000;
    rst_n = 1'b0;
    #1 check("rst_async", 2'b00, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    add(4'b0000, 0, 20, 2'b00, 2'd0, 0);
    run_tbl("post_rst");

    // three channels at once, pointer 0
    add(4'b1011, 0, 6, 2'b00, 2'd0, 0);
    add(4'b1011, 0, 1, 2'b01, 2'd0, 1);
    add(4'b1011, 0, 7, 2'b01, 2'd0, 1);
    add(4'b1011, 0, 1, 2'b00, 2'd0, 1);
    add(4'b1011, 0, 1, 2'b01, 2'd1, 1);
    add(4'b1011, 0, 7, 2'b01, 2'd1, 1);
    add(4'b1011, 0, 1, 2'b00, 2'd0, 1);
    add(4'b1011, 0, 1, 2'b01, 2'd3, 1);
    add(4'b1011, 0, 7, 2'b01, 2'd3, 0);
    add(4'b1011, 0, 2, 2'b00, 2'd0, 0);
    // three falls, clr while ch0 shows
    add(4'b0000, 0, 6, 2'b00, 2'd0, 0);
    add(4'b0000, 0, 1, 2'b10, 2'd0, 1);
    add(4'b0000, 0, 2, 2'b10, 2'd0, 1);
    add(4'b0000, 1, 1, 2'b00, 2'd0, 0);
    add(4'b0000, 0, 20, 2'b00, 2'd0, 0);
    run_tbl("multi");
`else
    // lockout: ch3 latches, ch0 ignored until clr
    add(4'b1000, 0, 6, 2'b00, 2'd0, 0);
    add(4'b1000, 0, 1, 2'b01, 2'd3, 0);
    add(4'b1001, 0, 20, 2'b01, 2'd3, 0);
    add(4'b1001, 1, 1, 2'b00, 2'd0, 0);
    add(4'b1001, 0, 4, 2'b00, 2'd0, 0);
    add(4'b1000, 0, 6, 2'b00, 2'd0, 0);
    add(4'b1000, 0, 1, 2'b10, 2'd0, 0);
    add(4'b1000, 0, 12, 2'b10, 2'd0, 0);
    run_tbl("lock");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
